// File: rtl/up_down_cntr_pkg.sv
// Shared types for the programmable up/down counter.
// Event codes and bound-handling mode encodings.
package up_down_cntr_pkg;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_OVF,
        EV_UNF
    } cnt_evt_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/up_down_cntr_mod_ud_step_calc.sv
// Combinational next-count calculator for one enabled step.
// Resolves range clamp, wrap/saturate and the boundary event.
module ud_step_calc
    import up_down_cntr_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic [N-1:0]      dout,
    input  logic [STEP_W-1:0] step,
    input  logic              up,
    input  logic [N-1:0]      max_val,
    input  logic              sat,
    output logic [N-1:0]      nxt,
    output cnt_evt_t          evt
);

    logic [N:0] step_x;
    logic [N:0] sum;
    logic [N:0] diff;

    assign step_x = {{(N + 1 - STEP_W){1'b0}}, step};
    assign sum    = {1'b0, dout} + step_x;
    assign diff   = {1'b0, dout} - step_x;

    // Pick next count; out-of-range snaps to the bound silently
    always_comb begin
        nxt = dout;
        evt = EV_NONE;
        if (dout > max_val) begin
            nxt = max_val;
        end else if (step == '0) begin
            nxt = dout;
        end else if (up) begin
            if (sum <= {1'b0, max_val}) begin
                nxt = sum[N-1:0];
            end else begin
                evt = EV_OVF;
                nxt = (sat == MODE_SAT) ? max_val : '0;
            end
        end else begin
            if (!diff[N]) begin
                nxt = diff[N-1:0];
            end else begin
                evt = EV_UNF;
                nxt = (sat == MODE_SAT) ? '0 : max_val;
            end
        end
    end

endmodule

// File: rtl/up_down_cntr_mod.sv
// Programmable up/down counter with load, step, modulus,
// wrap/saturate mode and terminal-count / sticky overflow flags.
module up_down_cntr_mod
    import up_down_cntr_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [N-1:0]      load_val,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      max_val,
    input  logic              sat,
    input  logic              clr_flag,
    output logic [N-1:0]      dout,
    output logic              tc,
    output logic              ovf_sticky,
    output logic              at_max,
    output logic              at_zero
);

    logic [N-1:0] nxt;
    cnt_evt_t     evt;
    logic         hit;

    ud_step_calc #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_calc (
        .dout    (dout),
        .step    (step),
        .up      (up),
        .max_val (max_val),
        .sat     (sat),
        .nxt     (nxt),
        .evt     (evt)
    );

    assign hit = en && !load && (evt != EV_NONE);

    // Count register: reset beats load beats enabled step
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            tc   <= 1'b0;
        end else if (load) begin
            dout <= (load_val > max_val) ? max_val : load_val;
            tc   <= 1'b0;
        end else if (en) begin
            dout <= nxt;
            tc   <= hit;
        end else begin
            tc   <= 1'b0;
        end
    end

    // Sticky flag: a new event wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (hit) begin
            ovf_sticky <= 1'b1;
        end else if (clr_flag) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign at_max  = (dout == max_val);
    assign at_zero = (dout == '0);

endmodule

// File: tb/tb_up_down_cntr_mod.sv
// Directed table-driven bench for up_down_cntr_mod (N=8, STEP_W=4).
// Expected values are hand-computed and carried in the vector table.
module tb_up_down_cntr_mod;

    localparam int N      = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst, en, up, load, sat, clr_flag;
    logic [N-1:0]      load_val, max_val;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      dout;
    logic              tc, ovf_sticky, at_max, at_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic              rst;
        logic              load;
        logic [N-1:0]      load_val;
        logic              en;
        logic              up;
        logic [STEP_W-1:0] step;
        logic [N-1:0]      max_val;
        logic              sat;
        logic              clr;
        logic [N-1:0]      e_dout;
        logic              e_tc;
        logic              e_ovf;
        logic              e_max;
        logic              e_zero;
    } vec_t;

    vec_t vecs[$];

    up_down_cntr_mod #(.N(N), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_val   (load_val),
        .step       (step),
        .max_val    (max_val),
        .sat        (sat),
        .clr_flag   (clr_flag),
        .dout       (dout),
        .tc         (tc),
        .ovf_sticky (ovf_sticky),
        .at_max     (at_max),
        .at_zero    (at_zero)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic ld, input int lv,
                       input logic e, input logic u, input int st,
                       input int mx, input logic s, input logic c,
                       input int ed, input logic et, input logic eo,
                       input logic em, input logic ez);
        vec_t v;
        v.rst = r; v.load = ld; v.load_val = lv[N-1:0];
        v.en = e; v.up = u; v.step = st[STEP_W-1:0];
        v.max_val = mx[N-1:0]; v.sat = s; v.clr = c;
        v.e_dout = ed[N-1:0]; v.e_tc = et; v.e_ovf = eo;
        v.e_max = em; v.e_zero = ez;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; load = v.load; load_val = v.load_val;
        en = v.en; up = v.up; step = v.step;
        max_val = v.max_val; sat = v.sat; clr_flag = v.clr;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d dout", idx), int'(dout), int'(v.e_dout));
        chk($sformatf("v%0d tc", idx), int'(tc), int'(v.e_tc));
        chk($sformatf("v%0d ovf", idx), int'(ovf_sticky), int'(v.e_ovf));
        chk($sformatf("v%0d at_max", idx), int'(at_max), int'(v.e_max));
        chk($sformatf("v%0d at_zero", idx), int'(at_zero), int'(v.e_zero));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b0;
        step = '0; max_val = '0; sat = 1'b0; clr_flag = 1'b0;

        //  r ld  lv e u st  mx s c   dout tc ovf max zero
        // reset, then load clamps to max_val
        add(1, 0,   0, 0, 0, 0, 150, 0, 0,   0, 0, 0, 0, 1);
        add(1, 0,   0, 0, 0, 0, 150, 0, 0,   0, 0, 0, 0, 1);
        add(0, 1, 200, 0, 0, 0, 150, 0, 0, 150, 0, 0, 1, 0);
        // wrap up by 3 in [0,9]
        add(0, 1,   0, 0, 0, 0,   9, 0, 0,   0, 0, 0, 0, 1);
        add(0, 0,   0, 1, 1, 3,   9, 0, 0,   3, 0, 0, 0, 0);
        add(0, 0,   0, 1, 1, 3,   9, 0, 0,   6, 0, 0, 0, 0);
        add(0, 0,   0, 1, 1, 3,   9, 0, 0,   9, 0, 0, 1, 0);
        add(0, 0,   0, 1, 1, 3,   9, 0, 0,   0, 1, 1, 0, 1);
        // saturate down by 4 from 9
        add(0, 1,   9, 0, 0, 0,   9, 1, 0,   9, 0, 1, 1, 0);
        add(0, 0,   0, 1, 0, 4,   9, 1, 0,   5, 0, 1, 0, 0);
        add(0, 0,   0, 1, 0, 4,   9, 1, 0,   1, 0, 1, 0, 0);
        add(0, 0,   0, 1, 0, 4,   9, 1, 0,   0, 1, 1, 0, 1);
        add(0, 0,   0, 1, 0, 4,   9, 1, 0,   0, 1, 1, 0, 1);
        // priority: rst > load > en
        add(1, 1,   7, 1, 1, 1,   9, 0, 0,   0, 0, 0, 0, 1);
        add(0, 1,   7, 1, 1, 1,   9, 0, 0,   7, 0, 0, 0, 0);
        // sticky: set beats same-cycle clear, then clear
        add(0, 0,   0, 1, 1, 3,   9, 0, 1,   0, 1, 1, 0, 1);
        add(0, 0,   0, 0, 1, 3,   9, 0, 1,   0, 0, 0, 0, 1);
        // range shrink then step 0
        add(0, 1,  12, 0, 0, 0,  15, 0, 0,  12, 0, 0, 0, 0);
        add(0, 0,   0, 1, 1, 3,   5, 0, 0,   5, 0, 0, 1, 0);
        add(0, 0,   0, 1, 1, 0,   5, 0, 0,   5, 0, 0, 1, 0);
        // max_val = 0: every step is an event
        add(0, 1,   0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 1, 1);
        add(0, 0,   0, 1, 1, 1,   0, 0, 0,   0, 1, 1, 1, 1);
        // down wrap, plain down, saturate up, hold
        add(0, 0,   0, 1, 0, 1,   9, 0, 0,   9, 1, 1, 1, 0);
        add(0, 0,   0, 1, 0, 4,   9, 0, 0,   5, 0, 1, 0, 0);
        add(0, 0,   0, 1, 1, 5,   9, 1, 0,   9, 1, 1, 1, 0);
        add(0, 0,   0, 0, 1, 5,   9, 1, 0,   9, 0, 1, 1, 0);
        // exact landing on max is not an event
        add(0, 1,   4, 0, 0, 0,   9, 0, 1,   4, 0, 0, 0, 0);
        add(0, 0,   0, 1, 1, 5,   9, 0, 0,   9, 0, 0, 1, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // saturated hold at max: tc on every crossing cycle
        load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd2;
        max_val = 8'd9; sat = 1'b1; clr_flag = 1'b0; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sathold%0d dout", k), int'(dout), 9);
            chk($sformatf("sathold%0d tc", k), int'(tc), 1);
            @(negedge clk);
        end

        // tc is a single-cycle pulse: wrap up by 7 in [0,20]
        load = 1'b1; load_val = 8'd0; max_val = 8'd20; sat = 1'b0;
        @(negedge clk);
        load = 1'b0; step = 4'd7;
        begin
            int exp_d;
            int nxt_d;
            exp_d = 0;
            for (int k = 0; k < 8; k++) begin
                nxt_d = exp_d + 7;
                @(posedge clk);
                #1;
                chk($sformatf("wrap%0d dout", k), int'(dout),
                    (nxt_d > 20) ? 0 : nxt_d);
                chk($sformatf("wrap%0d tc", k), int'(tc),
                    (nxt_d > 20) ? 1 : 0);
                exp_d = (nxt_d > 20) ? 0 : nxt_d;
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
